// File: rtl/f8_wdt_pkg.sv
// Register offsets, unlock key values and key-FSM state encoding shared by the
// watchdog I/O bridge and its key sub-module.
package f8_wdt_pkg;

  localparam logic [2:0] OFF_CNT_LO = 3'd0;
  localparam logic [2:0] OFF_CNT_HI = 3'd1;
  localparam logic [2:0] OFF_RLD_LO = 3'd2;
  localparam logic [2:0] OFF_RLD_HI = 3'd3;
  localparam logic [2:0] OFF_CONFIG = 3'd4;
  localparam logic [2:0] OFF_KEY    = 3'd5;

  localparam logic [7:0] KEY1_VAL = 8'h55;
  localparam logic [7:0] KEY2_VAL = 8'hAA;
  localparam logic [7:0] CLR_VAL  = 8'h00;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    KEY1     = 2'd1,
    UNLOCKED = 2'd2
  } key_state_e;

endpackage

// File: rtl/wdt_key_fsm.sv
// Two-step unlock sequence guarding CONFIG writes, with an inactivity timeout
// and a sticky violation flag for CONFIG writes attempted while not unlocked.
module wdt_key_fsm
  import f8_wdt_pkg::*;
#(
  parameter int KEY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_write,
  input  logic [7:0] key_data,
  input  logic       config_req,
  output key_state_e state,
  output logic       violation
);

  localparam int TW = (KEY_TIMEOUT > 1) ? $clog2(KEY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(KEY_TIMEOUT - 1);

  logic [TW-1:0] timer;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOCKED;
      timer     <= '0;
      violation <= 1'b0;
    end else if (key_write) begin
      timer <= '0;
      case (state)
        LOCKED: begin
          if (key_data == KEY1_VAL) state <= KEY1;
          if (key_data == CLR_VAL) violation <= 1'b0;
        end
        KEY1:    state <= (key_data == KEY2_VAL) ? UNLOCKED : LOCKED;
        default: state <= LOCKED;
      endcase
    end else if (config_req && state == UNLOCKED) begin
      state <= LOCKED;
      timer <= '0;
    end else begin
      if (config_req) violation <= 1'b1;
      // An open sequence expires after KEY_TIMEOUT cycles without a key write.
      if (state != LOCKED) begin
        if (timer == TIMER_LAST) begin
          state <= LOCKED;
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wdt_io_bridge.sv
// 8-bit CPU I/O port bridge to a 16-bit watchdog: address decode, registered
// read mux with high-byte snapshot, and low-byte buffering for 16-bit writes.
module wdt_io_bridge
  import f8_wdt_pkg::*;
#(
  parameter logic [7:0] BASE        = 8'h20,
  parameter int         KEY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  io_addr,
  input  logic [7:0]  io_wdata,
  input  logic        io_write,
  input  logic        io_read,
  output logic [7:0]  io_rdata,
  input  logic [15:0] wdt_counter,
  input  logic [15:0] wdt_reload,
  input  logic [7:0]  wdt_config,
  output logic [15:0] counter_in,
  output logic [15:0] reload_in,
  output logic [7:0]  config_in,
  output logic [1:0]  counter_write,
  output logic [1:0]  reload_write,
  output logic        config_write
);

  logic       sel;
  logic       wr;
  logic       rd;
  logic [2:0] offset;
  logic [7:0] read_data;
  logic [7:0] cnt_snapshot;
  logic [7:0] cnt_lo_buf;
  logic [7:0] rld_lo_buf;
  logic       cnt_pending;
  logic       rld_pending;
  key_state_e key_state;
  logic       violation;

  assign sel    = (io_addr[7:3] == BASE[7:3]);
  assign offset = io_addr[2:0];
  assign wr     = io_write && sel;
  // A simultaneous write wins; the read is dropped and io_rdata holds.
  assign rd     = io_read && !io_write;

  wdt_key_fsm #(.KEY_TIMEOUT(KEY_TIMEOUT)) u_key_fsm (
    .clk        (clk),
    .reset      (reset),
    .key_write  (wr && (offset == OFF_KEY)),
    .key_data   (io_wdata),
    .config_req (wr && (offset == OFF_CONFIG)),
    .state      (key_state),
    .violation  (violation)
  );

  // NOTE: every combinational output gets a default first so no latch forms.
  always_comb begin
    read_data = 8'h00;
    if (sel) begin
      case (offset)
        OFF_CNT_LO: read_data = wdt_counter[7:0];
        OFF_CNT_HI: read_data = cnt_snapshot;
        OFF_RLD_LO: read_data = wdt_reload[7:0];
        OFF_RLD_HI: read_data = wdt_reload[15:8];
        OFF_CONFIG: read_data = wdt_config;
        OFF_KEY:    read_data = {5'b0, violation, key_state};
        default:    read_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      io_rdata      <= '0;
      counter_in    <= '0;
      reload_in     <= '0;
      config_in     <= '0;
      counter_write <= '0;
      reload_write  <= '0;
      config_write  <= 1'b0;
      cnt_snapshot  <= '0;
      cnt_lo_buf    <= '0;
      rld_lo_buf    <= '0;
      cnt_pending   <= 1'b0;
      rld_pending   <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle, so any assignment below is a
      // single-cycle pulse; the data outputs keep their last value.
      counter_write <= 2'b00;
      reload_write  <= 2'b00;
      config_write  <= 1'b0;
      if (wr) begin
        case (offset)
          OFF_CNT_LO: begin
            cnt_lo_buf  <= io_wdata;
            cnt_pending <= 1'b1;
          end
          OFF_CNT_HI: begin
            counter_write <= {1'b1, cnt_pending};
            counter_in    <= {io_wdata, cnt_pending ? cnt_lo_buf : 8'h00};
            cnt_pending   <= 1'b0;
          end
          OFF_RLD_LO: begin
            rld_lo_buf  <= io_wdata;
            rld_pending <= 1'b1;
          end
          OFF_RLD_HI: begin
            reload_write <= {1'b1, rld_pending};
            reload_in    <= {io_wdata, rld_pending ? rld_lo_buf : 8'h00};
            rld_pending  <= 1'b0;
          end
          OFF_CONFIG: begin
            if (key_state == UNLOCKED) begin
              config_write <= 1'b1;
              config_in    <= io_wdata;
            end
          end
          default: ;
        endcase
      end else if (rd) begin
        io_rdata <= read_data;
        if (sel && offset == OFF_CNT_LO) cnt_snapshot <= wdt_counter[15:8];
      end
    end
  end

endmodule

// File: tb/tb_wdt_io_bridge.sv
// Bench for wdt_io_bridge: directed scenarios plus a randomized run against a
// behavioural model of the register map and unlock sequence.
module tb_wdt_io_bridge;

  localparam logic [7:0] BASE        = 8'h20;
  localparam int         KEY_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  io_addr = '0;
  logic [7:0]  io_wdata = '0;
  logic        io_write = 1'b0;
  logic        io_read = 1'b0;
  logic [7:0]  io_rdata;
  logic [15:0] wdt_counter = '0;
  logic [15:0] wdt_reload = '0;
  logic [7:0]  wdt_config = '0;
  logic [15:0] counter_in;
  logic [15:0] reload_in;
  logic [7:0]  config_in;
  logic [1:0]  counter_write;
  logic [1:0]  reload_write;
  logic        config_write;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  wdt_io_bridge #(.BASE(BASE), .KEY_TIMEOUT(KEY_TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_addr       (io_addr),
    .io_wdata      (io_wdata),
    .io_write      (io_write),
    .io_read       (io_read),
    .io_rdata      (io_rdata),
    .wdt_counter   (wdt_counter),
    .wdt_reload    (wdt_reload),
    .wdt_config    (wdt_config),
    .counter_in    (counter_in),
    .reload_in     (reload_in),
    .config_in     (config_in),
    .counter_write (counter_write),
    .reload_write  (reload_write),
    .config_write  (config_write)
  );

  // Behavioural model: phase 0 locked, 1 first key seen, 2 unlocked; an open
  // phase is alive at edge n while n - m_enter <= KEY_TIMEOUT.
  logic [7:0]  m_lo [2];
  bit          m_pend [2];
  int          m_phase;
  int          m_enter;
  bit          m_viol;
  logic [7:0]  m_snap;
  logic [7:0]  e_rdata;
  logic [15:0] e_cnt_in, e_rld_in;
  logic [7:0]  e_cfg_in;
  logic [1:0]  e_cnt_we, e_rld_we;
  logic        e_cfg_we;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic model_reset();
    m_lo[0] = '0; m_lo[1] = '0; m_pend[0] = 0; m_pend[1] = 0;
    m_phase = 0; m_enter = 0; m_viol = 0; m_snap = '0;
    e_rdata = '0; e_cnt_in = '0; e_rld_in = '0; e_cfg_in = '0;
    e_cnt_we = '0; e_rld_we = '0; e_cfg_we = 1'b0;
  endtask

  task automatic model_step(input bit w, input bit r, input logic [7:0] a,
                            input logic [7:0] d, input int n);
    bit sel;
    logic [2:0] off;
    int p;
    sel = (a[7:3] == BASE[7:3]);
    off = a[2:0];
    p = (m_phase != 0 && n - m_enter > KEY_TIMEOUT) ? 0 : m_phase;
    m_phase = p;
    e_cnt_we = 2'b00; e_rld_we = 2'b00; e_cfg_we = 1'b0;
    if (w && sel) begin
      case (off)
        3'd0, 3'd2: begin m_lo[off[1]] = d; m_pend[off[1]] = 1'b1; end
        3'd1: begin
          e_cnt_we = m_pend[0] ? 2'b11 : 2'b10;
          e_cnt_in = {d, m_pend[0] ? m_lo[0] : 8'h00};
          m_pend[0] = 1'b0;
        end
        3'd3: begin
          e_rld_we = m_pend[1] ? 2'b11 : 2'b10;
          e_rld_in = {d, m_pend[1] ? m_lo[1] : 8'h00};
          m_pend[1] = 1'b0;
        end
        3'd4: begin
          if (p == 2) begin e_cfg_we = 1'b1; e_cfg_in = d; m_phase = 0; end
          else m_viol = 1'b1;
        end
        3'd5: begin
          if (p == 0 && d == 8'h00) m_viol = 1'b0;
          if (p == 0 && d == 8'h55) begin m_phase = 1; m_enter = n; end
          else if (p == 1 && d == 8'hAA) begin m_phase = 2; m_enter = n; end
          else m_phase = 0;
        end
        default: ;
      endcase
    end else if (r && !w) begin
      e_rdata = 8'h00;
      if (sel) begin
        case (off)
          3'd0: begin e_rdata = wdt_counter[7:0]; m_snap = wdt_counter[15:8]; end
          3'd1: e_rdata = m_snap;
          3'd2: e_rdata = wdt_reload[7:0];
          3'd3: e_rdata = wdt_reload[15:8];
          3'd4: e_rdata = wdt_config;
          3'd5: e_rdata = {5'b0, m_viol, 2'(p)};
          default: e_rdata = 8'h00;
        endcase
      end
    end
  endtask

  task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
    io_addr = a; io_wdata = d; io_write = 1'b1; io_read = 1'b0;
    tick();
    io_write = 1'b0;
  endtask

  task automatic io_rd(input logic [7:0] a);
    io_addr = a; io_read = 1'b1; io_write = 1'b0;
    tick();
    io_read = 1'b0;
  endtask

  task automatic apply_reset();
    io_write = 1'b0; io_read = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; io_addr = BASE + 8'd1; io_wdata = 8'h77; io_write = 1'b1;
    tick();
    tick();
    reset = 1'b0; io_write = 1'b0;
    checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", io_rdata); end
    checks++; if (counter_write !== 2'b00) begin errors++; $display("FAIL reset_cnt_we got=%b exp=00", counter_write); end
    checks++; if (reload_write !== 2'b00 || config_write !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b/%b exp=00/0", reload_write, config_write); end
    checks++; if ({counter_in, reload_in, config_in} !== 40'h0) begin errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", counter_in, reload_in, config_in); end
    tick();
    checks++; if (counter_write !== 2'b00) begin errors++; $display("FAIL reset_late_strobe got=%b exp=00", counter_write); end
    io_rd(BASE + 8'd5);
    checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL reset_key got=%h exp=00", io_rdata); end
    io_rd(BASE + 8'd1);
    checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL reset_snapshot got=%h exp=00", io_rdata); end
  endtask

  task automatic test_byte_write();
    io_wr(BASE + 8'd0, 8'h34);
    checks++; if (counter_write !== 2'b00) begin errors++; $display("FAIL lo_no_strobe got=%b exp=00", counter_write); end
    io_wr(BASE + 8'd1, 8'h12);
    checks++; if (counter_write !== 2'b11 || counter_in !== 16'h1234) begin errors++; $display("FAIL cnt_pair got=%b/%h exp=11/1234", counter_write, counter_in); end
    tick();
    checks++; if (counter_write !== 2'b00 || counter_in !== 16'h1234) begin errors++; $display("FAIL cnt_one_cycle got=%b/%h exp=00/1234", counter_write, counter_in); end
    io_wr(BASE + 8'd1, 8'hAB);
    checks++; if (counter_write !== 2'b10 || counter_in !== 16'hAB00) begin errors++; $display("FAIL cnt_hi_only got=%b/%h exp=10/ab00", counter_write, counter_in); end
    io_wr(BASE + 8'd2, 8'h5A);
    io_wr(BASE + 8'd3, 8'hC3);
    checks++; if (reload_write !== 2'b11 || reload_in !== 16'hC35A || counter_write !== 2'b00) begin errors++; $display("FAIL rld_pair got=%b/%h/%b exp=11/c35a/00", reload_write, reload_in, counter_write); end
  endtask

  task automatic test_reads();
    wdt_counter = 16'h00FF;
    io_rd(BASE + 8'd0);
    checks++; if (io_rdata !== 8'hFF) begin errors++; $display("FAIL cnt_lo got=%h exp=ff", io_rdata); end
    wdt_counter = 16'h0100;
    io_rd(BASE + 8'd1);
    checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL cnt_hi_snap got=%h exp=00", io_rdata); end
    wdt_counter = 16'hABCD;
    io_rd(BASE + 8'd0);
    wdt_counter = 16'h0000;
    io_rd(BASE + 8'd1);
    tick();
    checks++; if (io_rdata !== 8'hAB) begin errors++; $display("FAIL snap_hold got=%h exp=ab", io_rdata); end
    wdt_reload = 16'hBEEF; wdt_config = 8'h5C;
    io_rd(BASE + 8'd2);
    checks++; if (io_rdata !== 8'hEF) begin errors++; $display("FAIL rld_lo got=%h exp=ef", io_rdata); end
    io_rd(BASE + 8'd3);
    checks++; if (io_rdata !== 8'hBE) begin errors++; $display("FAIL rld_hi got=%h exp=be", io_rdata); end
    io_rd(BASE + 8'd4);
    checks++; if (io_rdata !== 8'h5C) begin errors++; $display("FAIL cfg_rd got=%h exp=5c", io_rdata); end
    io_rd(BASE + 8'd7);
    checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL reserved_rd got=%h exp=00", io_rdata); end
  endtask

  task automatic test_config_locked();
    io_wr(BASE + 8'd4, 8'h01);
    checks++; if (config_write !== 1'b0) begin errors++; $display("FAIL locked_cfg got=%b exp=0", config_write); end
    io_rd(BASE + 8'd5);
    checks++; if (io_rdata !== 8'h04) begin errors++; $display("FAIL violation_set got=%h exp=04", io_rdata); end
    io_wr(BASE + 8'd5, 8'h00);
    io_rd(BASE + 8'd5);
    checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL violation_clr got=%h exp=00", io_rdata); end
  endtask

  task automatic test_unlock_config();
    io_wr(BASE + 8'd5, 8'h55);
    io_rd(BASE + 8'd5);
    checks++; if (io_rdata !== 8'h01) begin errors++; $display("FAIL key1_state got=%h exp=01", io_rdata); end
    io_wr(BASE + 8'd5, 8'hAA);
    io_rd(BASE + 8'd5);
    checks++; if (io_rdata !== 8'h02) begin errors++; $display("FAIL unlocked_state got=%h exp=02", io_rdata); end
    io_wr(BASE + 8'd4, 8'h01);
    checks++; if (config_write !== 1'b1 || config_in !== 8'h01) begin errors++; $display("FAIL cfg_pulse got=%b/%h exp=1/01", config_write, config_in); end
    tick();
    checks++; if (config_write !== 1'b0 || config_in !== 8'h01) begin errors++; $display("FAIL cfg_one_cycle got=%b/%h exp=0/01", config_write, config_in); end
    io_rd(BASE + 8'd5);
    checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL relocked got=%h exp=00", io_rdata); end
  endtask

  task automatic test_timeout();
    io_wr(BASE + 8'd5, 8'h55);
    repeat (KEY_TIMEOUT - 1) tick();
    io_wr(BASE + 8'd5, 8'hAA);
    io_rd(BASE + 8'd5);
    checks++; if (io_rdata !== 8'h02) begin errors++; $display("FAIL key_in_time got=%h exp=02", io_rdata); end
    io_wr(BASE + 8'd5, 8'h00);
    io_wr(BASE + 8'd5, 8'h55);
    repeat (KEY_TIMEOUT) tick();
    io_wr(BASE + 8'd5, 8'hAA);
    io_rd(BASE + 8'd5);
    checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL key_timeout got=%h exp=00", io_rdata); end
    io_wr(BASE + 8'd4, 8'h7E);
    checks++; if (config_write !== 1'b0) begin errors++; $display("FAIL timeout_cfg got=%b exp=0", config_write); end
    io_rd(BASE + 8'd5);
    checks++; if (io_rdata !== 8'h04) begin errors++; $display("FAIL timeout_violation got=%h exp=04", io_rdata); end
    io_wr(BASE + 8'd5, 8'h00);
  endtask

  task automatic test_reset_abort();
    io_wr(BASE + 8'd2, 8'h34);
    apply_reset();
    io_wr(BASE + 8'd3, 8'h12);
    checks++; if (reload_write !== 2'b10 || reload_in !== 16'h1200) begin errors++; $display("FAIL abort_pending got=%b/%h exp=10/1200", reload_write, reload_in); end
    io_wr(BASE + 8'd5, 8'h55);
    apply_reset();
    io_wr(BASE + 8'd5, 8'hAA);
    io_rd(BASE + 8'd5);
    checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL abort_unlock got=%h exp=00", io_rdata); end
  endtask

  task automatic test_collision();
    wdt_config = 8'h5C;
    io_rd(BASE + 8'd4);
    io_addr = BASE + 8'd1; io_wdata = 8'h99; io_write = 1'b1; io_read = 1'b1;
    tick();
    io_write = 1'b0; io_read = 1'b0;
    checks++; if (io_rdata !== 8'h5C) begin errors++; $display("FAIL collide_rdata got=%h exp=5c", io_rdata); end
    checks++; if (counter_write !== 2'b10 || counter_in !== 16'h9900) begin errors++; $display("FAIL collide_write got=%b/%h exp=10/9900", counter_write, counter_in); end
  endtask

  task automatic test_unselected();
    io_wr(8'h29, 8'h11);
    checks++; if (counter_write !== 2'b00) begin errors++; $display("FAIL unsel_write got=%b exp=00", counter_write); end
    io_wr(8'h2D, 8'h55);
    io_rd(BASE + 8'd5);
    checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL unsel_key got=%h exp=00", io_rdata); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      int kind;
      logic [7:0] a;
      logic [7:0] d;
      bit w;
      bit r;
      wdt_counter = 16'($urandom);
      wdt_reload  = 16'($urandom);
      wdt_config  = 8'($urandom);
      kind = $urandom_range(0, 9);
      a = BASE | 8'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = 8'($urandom);
      d = 8'($urandom);
      if (a[2:0] == 3'd5 && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 2))
          0:       d = 8'h55;
          1:       d = 8'hAA;
          default: d = 8'h00;
        endcase
      end
      w = (kind <= 3) || (kind == 6);
      r = (kind == 4) || (kind == 5) || (kind == 6);
      io_addr = a; io_wdata = d; io_write = w; io_read = r;
      tick();
      io_write = 1'b0; io_read = 1'b0;
      model_step(w, r, a, d, edge_n);
      checks++; if (io_rdata !== e_rdata) begin errors++; $display("FAIL rnd_rdata op=%0d got=%h exp=%h", i, io_rdata, e_rdata); end
      checks++; if (counter_write !== e_cnt_we || counter_in !== e_cnt_in) begin errors++; $display("FAIL rnd_counter op=%0d got=%b/%h exp=%b/%h", i, counter_write, counter_in, e_cnt_we, e_cnt_in); end
      checks++; if (reload_write !== e_rld_we || reload_in !== e_rld_in) begin errors++; $display("FAIL rnd_reload op=%0d got=%b/%h exp=%b/%h", i, reload_write, reload_in, e_rld_we, e_rld_in); end
      checks++; if (config_write !== e_cfg_we || config_in !== e_cfg_in) begin errors++; $display("FAIL rnd_config op=%0d got=%b/%h exp=%b/%h", i, config_write, config_in, e_cfg_we, e_cfg_in); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_byte_write();
    test_reads();
    test_config_locked();
    test_unlock_config();
    test_timeout();
    test_reset_abort();
    test_collision();
    test_unselected();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wdt_io_bridge.md
WDT_IO_BRIDGE -- requirements
Module: wdt_io_bridge

Interface
REQ-001 SHALL have parameter BASE, default 8'h20, I/O base address; aligned to 8, only BASE[7:3] is decoded.
REQ-002 SHALL have parameter KEY_TIMEOUT, default 16, number of cycles the unlock sequence stays open.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 io_addr  input  8  CPU I/O port address.
REQ-006 io_wdata  input  8  CPU write data.
REQ-007 io_write  input  1  one-cycle write strobe.
REQ-008 io_read  input  1  one-cycle read strobe.
REQ-009 io_rdata  output  8  read data, registered.
REQ-010 wdt_counter  input  16  live watchdog counter value.
REQ-011 wdt_reload  input  16  watchdog reload value.
REQ-012 wdt_config  input  8  watchdog config/status byte.
REQ-013 counter_in  output  16  counter write data to watchdog.
REQ-014 reload_in  output  16  reload write data to watchdog.
REQ-015 config_in  output  8  config write data to watchdog.
REQ-016 counter_write  output  2  counter byte enables [0]=low, [1]=high.
REQ-017 reload_write  output  2  reload byte enables.
REQ-018 config_write  output  1  config write strobe.

Function
REQ-019 Access SHALL be selected when io_addr[7:3]==BASE[7:3]; offset=io_addr[2:0]: 0 CNT_LO, 1 CNT_HI, 2 RLD_LO, 3 RLD_HI, 4 CONFIG, 5 KEY, 6-7 reserved.
REQ-020 Unselected or reserved accesses SHALL cause no state change and SHALL drive io_rdata=0.
REQ-021 Read latency SHALL be 1 cycle: io_rdata valid in the cycle after io_read and held until the next selected read.
REQ-022 Reading CNT_LO SHALL return wdt_counter[7:0] and snapshot wdt_counter[15:8]; reading CNT_HI SHALL return the snapshot (0 after reset).
REQ-023 RLD_LO/RLD_HI/CONFIG reads SHALL return wdt_reload[7:0]/wdt_reload[15:8]/wdt_config directly.
REQ-024 KEY read SHALL return {5'b0, violation, fsm_state[1:0]}.
REQ-025 Writing a LO offset SHALL only buffer the byte and set that register's pending flag; no strobe is issued.
REQ-026 Writing a HI offset SHALL, in the next cycle, pulse the write enables for one cycle: 2'b11 with {wdata, buffered byte} if pending, else 2'b10 with {wdata, 8'h00}; pending SHALL then clear.
REQ-027 Key FSM states: LOCKED(0), KEY1(1), UNLOCKED(2). LOCKED + KEY write 8'h55 -> KEY1; KEY1 + KEY write 8'hAA -> UNLOCKED; any other KEY write -> LOCKED.
REQ-028 In KEY1 or UNLOCKED, a cycle counter SHALL run; after KEY_TIMEOUT cycles without progress the FSM SHALL return to LOCKED.
REQ-029 CONFIG write in UNLOCKED SHALL pulse config_write with config_in=wdata in the next cycle, and the FSM SHALL return to LOCKED.
REQ-030 CONFIG write outside UNLOCKED SHALL be ignored and SHALL set sticky violation; a KEY write of 8'h00 in LOCKED SHALL clear violation.
REQ-031 io_write and io_read in the same cycle: write SHALL be performed, read ignored, io_rdata unchanged.
REQ-032 All strobes SHALL be single-cycle; data outputs SHALL hold their last value when strobes are low.

Reset
REQ-033 On reset: io_rdata=0, all strobes=0, counter_in/reload_in/config_in=0, snapshot=0, pending flags=0, FSM=LOCKED, timeout counter=0, violation=0.
REQ-034 Reset SHALL take priority over any access in the same cycle and SHALL abort an in-flight unlock sequence or pending LO byte; no strobe SHALL emerge after reset.

Structure
REQ-035 Package f8_wdt_pkg SHALL hold offset constants, KEY1_VAL=8'h55, KEY2_VAL=8'hAA, CLR_VAL=8'h00, and the key-FSM state enum.
REQ-036 The key FSM with its timeout counter SHALL be a sub-module wdt_key_fsm; decode, read mux and byte buffering stay in wdt_io_bridge.

Verification
REQ-037 Write 8'h34 to BASE+0, then 8'h12 to BASE+1 -> one cycle later counter_write=2'b11, counter_in=16'h1234, for exactly one cycle.
REQ-038 wdt_counter=16'h00FF, read BASE+0, then wdt_counter=16'h0100 and read BASE+1 -> io_rdata 8'hFF then 8'h00.
REQ-039 Write 8'h01 to BASE+4 while LOCKED -> no config_write, KEY read returns 8'h04.
REQ-040 KEY writes 8'h55, 8'hAA, then 8'h01 to BASE+4 -> config_write pulse with config_in=8'h01, FSM back to LOCKED.
REQ-041 KEY write 8'h55, idle 16 cycles, KEY write 8'hAA -> FSM LOCKED, later CONFIG write ignored.
REQ-042 Write 8'h34 to BASE+2, assert reset, then write 8'h12 to BASE+3 -> reload_write=2'b10, reload_in=16'h1200.
